key_voice_mixer: RTL and testbench
==================================

Name: key_voice_mixer

Overview:
- Output stage of the piano. Sits downstream of the per-note square-wave generators, each of which produces one 1-bit tone at a fixed pitch.
- Debounces the raw push-button keys and gates each note's square wave with its debounced key.
- Sums the active tones into a loudness level and drives a single 1-bit PWM audio pin for the speaker/RC filter.

Parameters:
- NUM_KEYS, 13, number of keys / note generators (C5..C6 chromatic).
- CLK_HZ, 50000000, system clock frequency.
- DEBOUNCE_CYCLES, 500000, stable cycles required before a key change is accepted (10 ms at 50 MHz).
- PWM_BITS, 8, PWM counter/duty width.
- MAX_VOICES, 4, level saturation point for mixing.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- key_in  input  NUM_KEYS  raw, bouncing, asynchronous push buttons; bit i = key i.
- note_in  input  NUM_KEYS  square waves from the note generators; clk-domain registered signals.
- key_active  output  NUM_KEYS  debounced key state; also drives the key LEDs.
- voice_count  output  clog2(NUM_KEYS+1)  number of debounced keys currently held.
- audio_pwm  output  1  PWM audio output.

Behaviour:
- Reset: all flops clear asynchronously.
  - key_active=0, voice_count=0, audio_pwm=0.
  - Synchronizers, debounce counters, level, duty and PWM counter all 0.
  - Reset asserted mid-debounce or mid-PWM-period discards all state. There is no partial recovery after release.
- Key path, per key:
  - 2-flop synchronizer on key_in[i].
  - Debounce counter counts while the synced value differs from key_active[i].
  - Counter clears to 0 on any cycle where synced == key_active[i].
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, key_active[i] flips on the next edge and the counter clears.
  - Press-to-key_active latency = 2 + DEBOUNCE_CYCLES cycles. Release latency is identical.
  - A bounce shorter than DEBOUNCE_CYCLES never changes key_active.
- voice_count = popcount(key_active), registered. It lags key_active by 1 cycle.
- Mixing:
  - gated[i] = note_in[i] & key_active[i], registered (stage 1).
  - level = min(popcount(gated), MAX_VOICES), registered (stage 2).
  - note_in edge to level change = 2 cycles.
- Duty:
  - SCALE = floor((2^PWM_BITS-1)/MAX_VOICES) = 63 for the defaults.
  - duty_next = level*SCALE, width PWM_BITS, which cannot overflow because of the saturation.
  - duty is latched only when pwm_cnt == 2^PWM_BITS-1, so the new duty takes effect from pwm_cnt==0. No mid-period duty change, so no glitch pulses.
- PWM:
  - pwm_cnt is free-running, PWM_BITS wide, and wraps 255->0. Period = 256 cycles (195.3 kHz).
  - audio_pwm registered: 1 when pwm_cnt < duty_latched.
  - duty 0 gives a constant 0.
  - Max duty 252 gives 252 high, 4 low per period.
- Simultaneous events:
  - Several keys may flip on the same cycle. Each key is handled independently.
  - A level change coinciding with the latch cycle uses the value present at that edge.
- More than MAX_VOICES tones high at once: level clamps to MAX_VOICES. There is no wrap.
- No keys held: level 0, audio_pwm constantly 0 from the next period.

Decomposition:
- Shared package piano_pkg holds:
  - CLK_HZ and NUM_KEYS constants.
  - The note index enum (NOTE_C5..NOTE_C6), which the note generators also use.
  - The SCALE computation function.
- One natural sub-module: key_debounce. It is single-bit, contains synchronizer plus counter, is parameterized by DEBOUNCE_CYCLES, and is instantiated NUM_KEYS times via generate.
- Popcount, saturation and PWM stay in the top level.

Test Plan (DEBOUNCE_CYCLES=16 in the bench; other parameters at default):
- Reset pulse mid-run with key 0 held and note_in toggling:
  - During reset: key_active=0, audio_pwm=0, voice_count=0.
  - After release: key_active[0] rises exactly 18 cycles after the first clean sample.
- key_in[3] bounce pattern 1,0,1,1,0, each level shorter than 16 cycles, then held 1 -> key_active[3] stays 0 until 16 stable cycles after the final rise, then goes 1; voice_count=1 one cycle later.
- Key 2 held, note_in[2] forced 1:
  - From the period after latching, duty=63 and audio_pwm is high for exactly 63 of every 256 cycles.
  - note_in[2] forced 0: audio_pwm is all 0 from the next period.
- Keys 0..5 held, all note_in=1 -> voice_count=6, level saturates at 4, duty=252, audio_pwm high 252 of 256 cycles.
- level changes 1->3 at pwm_cnt=100 -> the current period finishes with duty 63; the next period starts with duty 189 and shows no extra edge mid-period.
- Keys held but note_in[1] pressed with key 1 released -> gated[1]=0 and audio duty is unaffected by note_in[1].

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano datapath: board constants, the note
// index used by the note generators, and the PWM scale helper.
package piano_pkg;

  localparam int CLK_HZ   = 50_000_000;
  localparam int NUM_KEYS = 13;

  // One chromatic octave, C5..C6. Bit i of every key/note bus is note_e'(i).
  typedef enum logic [3:0] {
    NOTE_C5  = 4'd0,
    NOTE_CS5 = 4'd1,
    NOTE_D5  = 4'd2,
    NOTE_DS5 = 4'd3,
    NOTE_E5  = 4'd4,
    NOTE_F5  = 4'd5,
    NOTE_FS5 = 4'd6,
    NOTE_G5  = 4'd7,
    NOTE_GS5 = 4'd8,
    NOTE_A5  = 4'd9,
    NOTE_AS5 = 4'd10,
    NOTE_B5  = 4'd11,
    NOTE_C6  = 4'd12
  } note_e;

  // Duty step per voice: the largest step that keeps max_voices*step within
  // a pwm_bits-wide counter, so the saturated level never overflows the duty.
  function automatic int pwm_scale(input int pwm_bits, input int max_voices);
    return ((1 << pwm_bits) - 1) / max_voices;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchronizer on the raw button followed
// by a stability counter. The output only flips after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_stable
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the two
  // synchronizer stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= key_raw;
      sync_q    <= sync_meta;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count,
  // so a bounce shorter than the window never reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      key_stable <= 1'b0;
    end else if (sync_q == key_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      key_stable <= sync_q;
      cnt        <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_voice_mixer.sv
// Piano output stage: debounces every key, gates each note's square wave
// with its key, mixes the active tones into a saturated loudness level and
// drives one PWM audio pin. Duty only changes on a period boundary.
module key_voice_mixer #(
  parameter int NUM_KEYS        = piano_pkg::NUM_KEYS,
  parameter int CLK_HZ          = piano_pkg::CLK_HZ,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int PWM_BITS        = 8,
  parameter int MAX_VOICES      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           key_in,
  input  logic [NUM_KEYS-1:0]           note_in,
  output logic [NUM_KEYS-1:0]           key_active,
  output logic [$clog2(NUM_KEYS+1)-1:0] voice_count,
  output logic                          audio_pwm
);

  import piano_pkg::*;

  localparam int VW = $clog2(NUM_KEYS + 1);
  localparam int LW = $clog2(MAX_VOICES + 1);
  localparam logic [PWM_BITS-1:0] SCALE    = PWM_BITS'(pwm_scale(PWM_BITS, MAX_VOICES));
  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

  logic [NUM_KEYS-1:0] gated;
  logic [VW-1:0]       held_sum;
  logic [VW-1:0]       gated_sum;
  logic [LW-1:0]       level;
  logic [LW-1:0]       level_next;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] duty_latched;
  logic [PWM_BITS-1:0] pwm_cnt;

  // One independent debouncer per key; keys may flip on the same cycle.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[i]),
      .key_stable(key_active[i])
    );
  end

  // Population counts of held keys and of gated (sounding) tones.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    held_sum  = '0;
    gated_sum = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      held_sum  = held_sum + VW'(key_active[i]);
      gated_sum = gated_sum + VW'(gated[i]);
    end
  end

  // Clamp the number of sounding tones at MAX_VOICES instead of wrapping.
  always_comb begin
    level_next = LW'(MAX_VOICES);
    if (int'(gated_sum) < MAX_VOICES) begin
      level_next = LW'(gated_sum);
    end
  end

  // Saturation bounds level*SCALE below 2^PWM_BITS, so no overflow here.
  assign duty_next = PWM_BITS'(level) * SCALE;

  // Mixing pipeline: gate notes with keys, then register the clamped level;
  // voice_count trails key_active by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gated       <= '0;
      level       <= '0;
      voice_count <= '0;
    end else begin
      gated       <= note_in & key_active;
      level       <= level_next;
      voice_count <= held_sum;
    end
  end

  // Free-running PWM; duty is captured only on the last count of a period
  // so a level change never produces a partial or extra pulse mid-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt      <= '0;
      duty_latched <= '0;
      audio_pwm    <= 1'b0;
    end else begin
      pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      audio_pwm <= (pwm_cnt < duty_latched);
      if (pwm_cnt == CNT_LAST) begin
        duty_latched <= duty_next;
      end
    end
  end

endmodule

// File: tb/tb_key_voice_mixer.sv
// Directed bench for key_voice_mixer with a 16-cycle debounce window.
// The PWM phase is tracked by a bench-side edge counter that restarts with
// reset, so every audio sample has a known position in its period.
module tb_key_voice_mixer;

  localparam int NK = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_in = '0;
  logic [NK-1:0] note_in = '0;
  logic [NK-1:0] key_active;
  logic [3:0]    voice_count;
  logic          audio_pwm;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;

  key_voice_mixer #(
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_in     (key_in),
    .note_in    (note_in),
    .key_active (key_active),
    .voice_count(voice_count),
    .audio_pwm  (audio_pwm)
  );

  always #5 clk = ~clk;

  // Expected PWM counter: edges since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_phase(input int p);
    while ((edge_cnt % 256) != p) tick(1);
  endtask

  // Runs n cycles; counts high samples and samples that differ from an ideal
  // waveform with the given duty at the tracked phase.
  task automatic measure(input int n, input int exp_duty, output int highs, output int wrong);
    int  ph;
    logic exp_bit;
    highs = 0;
    wrong = 0;
    repeat (n) begin
      tick(1);
      ph = (edge_cnt - 1) % 256;
      exp_bit = (ph < exp_duty);
      if (audio_pwm === 1'b1) highs++;
      if (audio_pwm !== exp_bit) wrong++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_in = '0;
    note_in = '0;
    tick(3);
    total++; if (key_active !== 13'h0) begin bad++; $display("FAIL reset_init_keys: got %h expected 0", key_active); end
    total++; if (voice_count !== 4'd0) begin bad++; $display("FAIL reset_init_voices: got %0d expected 0", voice_count); end
    total++; if (audio_pwm !== 1'b0) begin bad++; $display("FAIL reset_init_audio: got %b expected 0", audio_pwm); end

    reset = 1'b0;
    key_in[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      note_in[0] = ~note_in[0];
      tick(1);
    end
    total++; if (key_active[0] !== 1'b1) begin bad++; $display("FAIL pre_reset_key0: got %b expected 1", key_active[0]); end

    reset = 1'b1;
    #1;
    total++; if (key_active !== 13'h0) begin bad++; $display("FAIL reset_async_keys: got %h expected 0", key_active); end
    total++; if (voice_count !== 4'd0) begin bad++; $display("FAIL reset_async_voices: got %0d expected 0", voice_count); end
    total++; if (audio_pwm !== 1'b0) begin bad++; $display("FAIL reset_async_audio: got %b expected 0", audio_pwm); end
    for (int i = 0; i < 2; i++) begin
      note_in[0] = ~note_in[0];
      tick(1);
    end
    total++; if (key_active !== 13'h0) begin bad++; $display("FAIL reset_held_keys: got %h expected 0", key_active); end
    total++; if (voice_count !== 4'd0) begin bad++; $display("FAIL reset_held_voices: got %0d expected 0", voice_count); end
    total++; if (audio_pwm !== 1'b0) begin bad++; $display("FAIL reset_held_audio: got %b expected 0", audio_pwm); end

    reset = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      note_in[0] = ~note_in[0];
      tick(1);
      if (i == 17) begin
        total++; if (key_active[0] !== 1'b0) begin bad++; $display("FAIL key0_early: got %b expected 0 at cycle 17", key_active[0]); end
      end
    end
    total++; if (key_active[0] !== 1'b1) begin bad++; $display("FAIL key0_rise: got %b expected 1 at cycle 18", key_active[0]); end
    tick(1);
    total++; if (voice_count !== 4'd1) begin bad++; $display("FAIL key0_voices: got %0d expected 1", voice_count); end
  endtask

  task automatic release_all();
    key_in = '0;
    note_in = '0;
    tick(40);
    total++; if (key_active !== 13'h0) begin bad++; $display("FAIL release_keys: got %h expected 0", key_active); end
    total++; if (voice_count !== 4'd0) begin bad++; $display("FAIL release_voices: got %0d expected 0", voice_count); end
  endtask

  task automatic test_bounce();
    logic vals[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   lens[5] = '{5, 3, 7, 6, 4};
    int   early = 0;
    for (int j = 0; j < 5; j++) begin
      key_in[3] = vals[j];
      for (int c = 0; c < lens[j]; c++) begin
        tick(1);
        if (key_active[3] !== 1'b0) early++;
      end
    end
    total++; if (early !== 0) begin bad++; $display("FAIL bounce_ignored: got %0d high cycles expected 0", early); end
    key_in[3] = 1'b1;
    tick(17);
    total++; if (key_active[3] !== 1'b0) begin bad++; $display("FAIL bounce_early: got %b expected 0", key_active[3]); end
    tick(1);
    total++; if (key_active[3] !== 1'b1) begin bad++; $display("FAIL bounce_rise: got %b expected 1", key_active[3]); end
    total++; if (voice_count !== 4'd0) begin bad++; $display("FAIL bounce_voice_lag: got %0d expected 0", voice_count); end
    tick(1);
    total++; if (voice_count !== 4'd1) begin bad++; $display("FAIL bounce_voices: got %0d expected 1", voice_count); end
  endtask

  task automatic test_single_voice();
    int h;
    int w;
    key_in[2] = 1'b1;
    note_in[2] = 1'b1;
    tick(25);
    wait_phase(0);
    measure(256, 63, h, w);
    total++; if (h !== 63) begin bad++; $display("FAIL one_voice_highs: got %0d expected 63", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL one_voice_shape: got %0d misplaced expected 0", w); end
    wait_phase(50);
    note_in[2] = 1'b0;
    wait_phase(0);
    measure(256, 0, h, w);
    total++; if (h !== 0) begin bad++; $display("FAIL silent_highs: got %0d expected 0", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL silent_shape: got %0d misplaced expected 0", w); end
  endtask

  task automatic test_saturation();
    int h;
    int w;
    key_in = 13'h03F;
    note_in = '1;
    tick(25);
    total++; if (voice_count !== 4'd6) begin bad++; $display("FAIL sat_voices: got %0d expected 6", voice_count); end
    wait_phase(0);
    measure(256, 252, h, w);
    total++; if (h !== 252) begin bad++; $display("FAIL sat_highs: got %0d expected 252", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL sat_shape: got %0d misplaced expected 0", w); end
  endtask

  task automatic test_mid_period_change();
    int h;
    int w;
    note_in = 13'h001;
    tick(5);
    wait_phase(0);
    measure(98, 63, h, w);
    total++; if (h !== 63) begin bad++; $display("FAIL mid_head_highs: got %0d expected 63", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL mid_head_shape: got %0d misplaced expected 0", w); end
    note_in = 13'h007;
    measure(158, 63, h, w);
    total++; if (h !== 0) begin bad++; $display("FAIL mid_tail_highs: got %0d expected 0", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL mid_tail_shape: got %0d misplaced expected 0", w); end
    measure(256, 189, h, w);
    total++; if (h !== 189) begin bad++; $display("FAIL mid_next_highs: got %0d expected 189", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL mid_next_shape: got %0d misplaced expected 0", w); end
  endtask

  task automatic test_gating();
    int h;
    int w;
    key_in = 13'h03D;
    note_in = 13'h003;
    tick(25);
    total++; if (key_active !== 13'h03D) begin bad++; $display("FAIL gate_keys: got %h expected 03d", key_active); end
    total++; if (voice_count !== 4'd5) begin bad++; $display("FAIL gate_voices: got %0d expected 5", voice_count); end
    total++; if (dut.gated !== 13'h001) begin bad++; $display("FAIL gate_mask: got %h expected 001", dut.gated); end
    wait_phase(0);
    measure(256, 63, h, w);
    total++; if (h !== 63) begin bad++; $display("FAIL gate_highs: got %0d expected 63", h); end
    total++; if (w !== 0) begin bad++; $display("FAIL gate_shape: got %0d misplaced expected 0", w); end
  endtask

  initial begin
    test_reset();
    release_all();
    test_bounce();
    release_all();
    test_single_voice();
    test_saturation();
    test_mid_period_change();
    test_gating();
    release_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
